// File: rtl/fpa_mant_addsub_norm.sv
// FP64 adder mantissa add/subtract and normalise stage: two registered stages
// with valid/ready handshaking; the result fraction is truncated, not rounded.
module fpa_mant_addsub_norm #(
  parameter int MW = 54,
  parameter int EW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MW-1:0] in_bigreg,
  input  logic [MW-1:0] in_smallreg,
  input  logic [EW-1:0] in_exp,
  input  logic          in_sign_big,
  input  logic          in_sign_small,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic [EW-1:0] out_exp,
  output logic [MW-3:0] out_frac,
  output logic          out_zero,
  output logic          out_ovf
);

  localparam int FW = MW - 2;
  localparam logic [EW-1:0] EXP_MAX = '1;

  logic          adv1, adv2;
  logic          s1_valid;
  logic [MW-1:0] s1_sum;
  logic          s1_sign;
  logic [EW-1:0] s1_exp;

  logic [MW-1:0] sum_c;
  logic          sign_c;
  logic [EW-1:0] exp_eff_c;

  logic [EW:0]   lz, exp_m1, exp_inc, sh;
  logic [FW:0]   norm;
  logic          n_sign, n_zero, n_ovf;
  logic [EW-1:0] n_exp;
  logic [FW-1:0] n_frac;

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;

  // Subtracting with equal exponents can leave small > big; swap so the magnitude stays positive.
  always_comb begin
    sum_c  = in_bigreg + in_smallreg;
    sign_c = in_sign_big;
    if (in_sign_big ^ in_sign_small) begin
      if (in_smallreg > in_bigreg) begin
        sum_c  = in_smallreg - in_bigreg;
        sign_c = in_sign_small;
      end else begin
        sum_c  = in_bigreg - in_smallreg;
      end
    end
    exp_eff_c = (in_exp == '0) ? EW'(1) : in_exp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sum  <= sum_c;
        s1_sign <= sign_c;
        s1_exp  <= exp_eff_c;
      end
    end
  end

  // Leading-zero count over the hidden-bit field; the highest set bit wins.
  always_comb begin
    lz = (EW+1)'(FW + 1);
    for (int i = 0; i <= FW; i++) begin
      if (s1_sum[i]) lz = (EW+1)'(FW - i);
    end
  end

  // Left shift is capped so the exponent never drops below 1 (gradual underflow).
  assign exp_m1  = {1'b0, s1_exp} - (EW+1)'(1);
  assign exp_inc = {1'b0, s1_exp} + (EW+1)'(1);
  assign sh      = (lz < exp_m1) ? lz : exp_m1;
  assign norm    = s1_sum[FW:0] << sh;

  always_comb begin
    n_sign = s1_sign;
    n_zero = 1'b0;
    n_ovf  = 1'b0;
    n_exp  = '0;
    n_frac = '0;
    if (s1_sum == '0) begin
      n_sign = 1'b0;
      n_zero = 1'b1;
    end else if (s1_sum[MW-1]) begin
      if (exp_inc >= {1'b0, EXP_MAX}) begin
        n_ovf = 1'b1;
        n_exp = EXP_MAX;
      end else begin
        n_exp  = exp_inc[EW-1:0];
        n_frac = s1_sum[FW:1];
      end
    end else begin
      n_exp  = norm[FW] ? (s1_exp - sh[EW-1:0]) : '0;
      n_frac = norm[FW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_exp   <= '0;
      out_frac  <= '0;
      out_zero  <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sign <= n_sign;
        out_exp  <= n_exp;
        out_frac <= n_frac;
        out_zero <= n_zero;
        out_ovf  <= n_ovf;
      end
    end
  end

endmodule
